// File: rtl/soma_lif.sv
// Leaky-integrate-and-fire soma: shift-decay integration of signed weight events,
// threshold firing with axon-delayed timestamps and event-time refractory. Optional SOMA_VLEAK_EN.
module soma_lif #(
  parameter int V_W      = 16,
  parameter int W_W      = 16,
  parameter int T_W      = 16,
  parameter int TAU_LOG2 = 3,
  parameter int AD_W     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            en,
  input  logic            cfg_we,
  input  logic [V_W-1:0]  cfg_vth,
  input  logic [V_W-1:0]  cfg_vleak,
  input  logic [T_W-1:0]  cfg_refr,
  input  logic [AD_W-1:0] cfg_axon,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W_W-1:0]  in_weight,
  input  logic [T_W-1:0]  in_interval,
  output logic            spike_valid,
  output logic [T_W-1:0]  spike_time,
  output logic [V_W-1:0]  v_mem,
  output logic            o_wait
);

  // One spare bit for the unsigned potential plus one for the carry/sign of the sum.
  localparam int SUM_W = ((V_W + 1 > W_W) ? V_W + 1 : W_W) + 1;
  localparam logic [T_W-1:0] V_W_T = T_W'(V_W);

  typedef enum logic [1:0] {
    DEACTIVE   = 2'd0,
    ACTIVE     = 2'd1,
    REFRACTORY = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [V_W-1:0]  v_q, v_d;
  logic [T_W-1:0]  ts_q, ts_d;
  logic [T_W-1:0]  refr_q, refr_d;
  logic            spike_valid_q, spike_valid_d;
  logic [T_W-1:0]  spike_time_q, spike_time_d;
  logic [V_W-1:0]  cfg_vth_q, cfg_vth_d;
  logic [T_W-1:0]  cfg_refr_q, cfg_refr_d;
  logic [AD_W-1:0] cfg_axon_q, cfg_axon_d;

  logic [T_W-1:0]   shift_amt;
  logic [V_W-1:0]   v_shift;
  logic [V_W-1:0]   v_leak;
  logic [V_W-1:0]   v_base;
  logic [SUM_W-1:0] sum;
  logic [V_W-1:0]   v_new;
  logic             fire;
  logic [T_W-1:0]   ts_sum;
  logic             do_int;

`ifdef SOMA_VLEAK_EN
  logic [V_W-1:0] cfg_vleak_q, cfg_vleak_d;
`else
  logic unused_vleak;
  assign unused_vleak = ^cfg_vleak;
`endif

  assign in_ready    = (state_q != DEACTIVE);
  assign o_wait      = (state_q == REFRACTORY);
  assign v_mem       = v_q;
  assign spike_valid = spike_valid_q;
  assign spike_time  = spike_time_q;

  // Datapath: decay, optional leak, signed add with saturation and floor.
  always_comb begin
    shift_amt = in_interval >> TAU_LOG2;
    if (shift_amt >= V_W_T) begin
      v_shift = '0;
    end else begin
      v_shift = v_q >> shift_amt;
    end
`ifdef SOMA_VLEAK_EN
    v_leak = (v_shift > cfg_vleak_q) ? (v_shift - cfg_vleak_q) : '0;
`else
    v_leak = v_shift;
`endif
    // Leaving refractory integrates from rest, without decay.
    v_base = (state_q == REFRACTORY) ? '0 : v_leak;
    sum = {{(SUM_W - V_W){1'b0}}, v_base}
        + {{(SUM_W - W_W){in_weight[W_W-1]}}, in_weight};
    if (sum[SUM_W-1]) begin
      v_new = '0;
    end else if (|sum[SUM_W-2:V_W]) begin
      v_new = '1;
    end else begin
      v_new = sum[V_W-1:0];
    end
    fire   = (cfg_vth_q != '0) && (v_new >= cfg_vth_q);
    ts_sum = ts_q + in_interval;
  end

  always_comb begin
    state_d       = state_q;
    v_d           = v_q;
    ts_d          = ts_q;
    refr_d        = refr_q;
    spike_valid_d = 1'b0;
    spike_time_d  = spike_time_q;
    do_int        = 1'b0;
    cfg_vth_d     = cfg_we ? cfg_vth  : cfg_vth_q;
    cfg_refr_d    = cfg_we ? cfg_refr : cfg_refr_q;
    cfg_axon_d    = cfg_we ? cfg_axon : cfg_axon_q;
`ifdef SOMA_VLEAK_EN
    cfg_vleak_d   = cfg_we ? cfg_vleak : cfg_vleak_q;
`endif

    if (kill) begin
      state_d = DEACTIVE;
      v_d     = '0;
      refr_d  = '0;
      ts_d    = '0;
    end else begin
      case (state_q)
        DEACTIVE: begin
          if (en) state_d = ACTIVE;
        end
        ACTIVE: begin
          if (!en) begin
            state_d = DEACTIVE;
          end else if (in_valid) begin
            ts_d   = ts_sum;
            do_int = 1'b1;
          end
        end
        REFRACTORY: begin
          if (!en) begin
            state_d = DEACTIVE;
            refr_d  = '0;
          end else if (in_valid) begin
            ts_d = ts_sum;
            if (in_interval < refr_q) begin
              refr_d = refr_q - in_interval;
            end else begin
              state_d = ACTIVE;
              refr_d  = '0;
              do_int  = 1'b1;
            end
          end
        end
        default: state_d = DEACTIVE;
      endcase

      if (do_int) begin
        if (fire) begin
          v_d           = '0;
          spike_valid_d = 1'b1;
          spike_time_d  = ts_sum + T_W'(cfg_axon_q);
          if (cfg_refr_q != '0) begin
            state_d = REFRACTORY;
            refr_d  = cfg_refr_q;
          end
        end else begin
          v_d = v_new;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= DEACTIVE;
      v_q           <= '0;
      ts_q          <= '0;
      refr_q        <= '0;
      spike_valid_q <= 1'b0;
      spike_time_q  <= '0;
      cfg_vth_q     <= '0;
      cfg_refr_q    <= '0;
      cfg_axon_q    <= '0;
`ifdef SOMA_VLEAK_EN
      cfg_vleak_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      v_q           <= v_d;
      ts_q          <= ts_d;
      refr_q        <= refr_d;
      spike_valid_q <= spike_valid_d;
      spike_time_q  <= spike_time_d;
      cfg_vth_q     <= cfg_vth_d;
      cfg_refr_q    <= cfg_refr_d;
      cfg_axon_q    <= cfg_axon_d;
`ifdef SOMA_VLEAK_EN
      cfg_vleak_q   <= cfg_vleak_d;
`endif
    end
  end

endmodule

// File: tb/tb_soma_lif.sv
// Bench for soma_lif: directed vector table, async-reset check, and randomized
// events against an integer reference model of the neuron rules.
module tb_soma_lif;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kill = 1'b0;
  logic        en = 1'b0;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_vth = '0;
  logic [15:0] cfg_vleak = '0;
  logic [15:0] cfg_refr = '0;
  logic [7:0]  cfg_axon = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_weight = '0;
  logic [15:0] in_interval = '0;
  logic        spike_valid;
  logic [15:0] spike_time;
  logic [15:0] v_mem;
  logic        o_wait;

  soma_lif dut (
    .clk        (clk),
    .rst        (rst),
    .kill       (kill),
    .en         (en),
    .cfg_we     (cfg_we),
    .cfg_vth    (cfg_vth),
    .cfg_vleak  (cfg_vleak),
    .cfg_refr   (cfg_refr),
    .cfg_axon   (cfg_axon),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_weight  (in_weight),
    .in_interval(in_interval),
    .spike_valid(spike_valid),
    .spike_time (spike_time),
    .v_mem      (v_mem),
    .o_wait     (o_wait)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: mode 0 = off, 1 = integrating, 2 = refractory.
  int m_mode, m_v, m_ts, m_refr, m_vth, m_rcfg, m_axon, m_vleak, m_st;
  bit m_spk;

  typedef struct {
    logic en, kill, we;
    int   vth, refr, axon;
    logic iv;
    int   w, intv;
    int   ev;
    logic es;
    int   est;
    logic ewait, erdy;
  } vec_t;

  localparam int NV = 34;
  vec_t tbl[NV];

  function automatic vec_t mk(logic en_i, logic kill_i, logic we_i, int vth_i, int refr_i,
                              int axon_i, logic iv_i, int w_i, int intv_i, int ev_i,
                              logic es_i, int est_i, logic ewait_i, logic erdy_i);
    vec_t r;
    r.en = en_i; r.kill = kill_i; r.we = we_i; r.vth = vth_i; r.refr = refr_i;
    r.axon = axon_i; r.iv = iv_i; r.w = w_i; r.intv = intv_i; r.ev = ev_i;
    r.es = es_i; r.est = est_i; r.ewait = ewait_i; r.erdy = erdy_i;
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_v = 0; m_ts = 0; m_refr = 0; m_vth = 0; m_rcfg = 0;
    m_axon = 0; m_vleak = 0; m_st = 0; m_spk = 0;
  endtask

  // Applies the neuron rules to the inputs currently driven, for one clock edge.
  task automatic model_step();
    int  s, vd, vn, w;
    bit  integ;
    integ = 0;
    vd = 0;
    m_spk = 0;
    w = int'($signed(in_weight));
    if (kill) begin
      m_mode = 0; m_v = 0; m_refr = 0; m_ts = 0;
    end else if (m_mode == 0) begin
      if (en) m_mode = 1;
    end else if (!en) begin
      if (m_mode == 2) m_refr = 0;
      m_mode = 0;
    end else if (in_valid) begin
      m_ts = (m_ts + int'(in_interval)) % 65536;
      if (m_mode == 1) begin
        s = int'(in_interval) / 8;
        vd = (s >= 16) ? 0 : (m_v / (1 << s));
`ifdef SOMA_VLEAK_EN
        vd = (vd > m_vleak) ? vd - m_vleak : 0;
`endif
        integ = 1;
      end else if (int'(in_interval) < m_refr) begin
        m_refr = m_refr - int'(in_interval);
      end else begin
        m_mode = 1; m_refr = 0; vd = 0; integ = 1;
      end
    end
    if (integ) begin
      vn = vd + w;
      if (vn < 0) vn = 0;
      if (vn > 65535) vn = 65535;
      if (m_vth != 0 && vn >= m_vth) begin
        m_spk = 1;
        m_st = (m_ts + m_axon) % 65536;
        m_v = 0;
        if (m_rcfg != 0) begin
          m_mode = 2; m_refr = m_rcfg;
        end
      end else begin
        m_v = vn;
      end
    end
    if (cfg_we) begin
      m_vth = int'(cfg_vth); m_rcfg = int'(cfg_refr);
      m_axon = int'(cfg_axon); m_vleak = int'(cfg_vleak);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(string tag);
    chk({tag, "_v"}, int'(v_mem), m_v);
    chk({tag, "_spk"}, int'(spike_valid), int'(m_spk));
    chk({tag, "_wait"}, int'(o_wait), (m_mode == 2) ? 1 : 0);
    chk({tag, "_rdy"}, int'(in_ready), (m_mode != 0) ? 1 : 0);
    if (m_spk) chk({tag, "_st"}, int'(spike_time), m_st);
  endtask

  initial begin
    // en, kill, we, vth, refr, axon, iv, w, intv | v, spike, stime, wait, ready
    tbl[0]  = mk(1,0,1,100,0,3,   0,0,0,        0,0,0,0,1);
    tbl[1]  = mk(1,0,0,0,0,0,     1,60,0,       60,0,0,0,1);
    tbl[2]  = mk(1,0,0,0,0,0,     1,50,8,       80,0,0,0,1);
    tbl[3]  = mk(1,0,0,0,0,0,     1,30,0,       0,1,11,0,1);
    tbl[4]  = mk(1,0,1,100,10,3,  0,0,0,        0,0,0,0,1);
    tbl[5]  = mk(1,0,0,0,0,0,     1,150,2,      0,1,13,1,1);
    tbl[6]  = mk(1,0,0,0,0,0,     1,200,4,      0,0,0,1,1);
    tbl[7]  = mk(1,0,0,0,0,0,     1,40,6,       40,0,0,0,1);
    tbl[8]  = mk(1,0,0,0,0,0,     1,-20,0,      20,0,0,0,1);
    tbl[9]  = mk(1,0,0,0,0,0,     1,-50,0,      0,0,0,0,1);
    tbl[10] = mk(1,0,1,0,10,3,    0,0,0,        0,0,0,0,1);
    tbl[11] = mk(1,0,0,0,0,0,     1,32767,0,    32767,0,0,0,1);
    tbl[12] = mk(1,0,0,0,0,0,     1,32733,0,    65500,0,0,0,1);
    tbl[13] = mk(1,0,0,0,0,0,     1,100,0,      65535,0,0,0,1);
    tbl[14] = mk(1,0,0,0,0,0,     1,-32768,0,   32767,0,0,0,1);
    tbl[15] = mk(1,0,0,0,0,0,     1,-31767,0,   1000,0,0,0,1);
    tbl[16] = mk(1,0,0,0,0,0,     1,0,128,      0,0,0,0,1);
    tbl[17] = mk(1,0,0,0,0,0,     1,0,65382,    0,0,0,0,1);
    tbl[18] = mk(1,0,1,100,0,3,   0,0,0,        0,0,0,0,1);
    tbl[19] = mk(1,0,0,0,0,0,     1,100,16,     0,1,13,0,1);
    tbl[20] = mk(1,0,0,0,0,0,     1,60,0,       60,0,0,0,1);
    tbl[21] = mk(1,0,1,200,0,3,   1,50,0,       0,1,13,0,1);
    tbl[22] = mk(1,0,0,0,0,0,     1,150,0,      150,0,0,0,1);
    tbl[23] = mk(1,0,1,200,50,3,  1,60,0,       0,1,13,0,1);
    tbl[24] = mk(1,0,0,0,0,0,     1,250,0,      0,1,13,1,1);
    tbl[25] = mk(1,1,0,0,0,0,     0,0,0,        0,0,0,0,0);
    tbl[26] = mk(1,0,0,0,0,0,     0,0,0,        0,0,0,0,1);
    tbl[27] = mk(1,0,0,0,0,0,     1,70,0,       70,0,0,0,1);
    tbl[28] = mk(0,0,0,0,0,0,     0,0,0,        70,0,0,0,0);
    tbl[29] = mk(1,0,0,0,0,0,     0,0,0,        70,0,0,0,1);
    tbl[30] = mk(1,0,1,10,0,3,    0,0,0,        70,0,0,0,1);
    tbl[31] = mk(1,0,0,0,0,0,     1,20,0,       0,1,3,0,1);
    tbl[32] = mk(1,0,0,0,0,0,     1,20,0,       0,1,3,0,1);
    tbl[33] = mk(1,0,0,0,0,0,     0,0,0,        0,0,0,0,1);

    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_v", int'(v_mem), 0);
    chk("rst_spk", int'(spike_valid), 0);
    chk("rst_st", int'(spike_time), 0);
    chk("rst_rdy", int'(in_ready), 0);
    chk("rst_wait", int'(o_wait), 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      en = tbl[i].en; kill = tbl[i].kill; cfg_we = tbl[i].we;
      cfg_vth = 16'(tbl[i].vth); cfg_refr = 16'(tbl[i].refr); cfg_axon = 8'(tbl[i].axon);
      cfg_vleak = '0;
      in_valid = tbl[i].iv; in_weight = 16'(tbl[i].w); in_interval = 16'(tbl[i].intv);
      tick();
      $display("[TB] vec %0d w=%0d int=%0d -> v=%0d spk=%0d st=%0d wait=%0d rdy=%0d",
               i, tbl[i].w, tbl[i].intv, v_mem, spike_valid, spike_time, o_wait, in_ready);
      chk($sformatf("vec%0d_v", i), int'(v_mem), tbl[i].ev);
      chk($sformatf("vec%0d_spk", i), int'(spike_valid), int'(tbl[i].es));
      chk($sformatf("vec%0d_wait", i), int'(o_wait), int'(tbl[i].ewait));
      chk($sformatf("vec%0d_rdy", i), int'(in_ready), int'(tbl[i].erdy));
      if (tbl[i].es) chk($sformatf("vec%0d_st", i), int'(spike_time), tbl[i].est);
    end

    // Asynchronous reset asserted between edges while a spike is being presented.
    en = 1; kill = 0; cfg_we = 0; in_valid = 1; in_weight = 16'd50; in_interval = 16'd0;
    tick();
    check_model("pre_arst");
    #2 rst = 1'b1;
    #1;
    chk("arst_v", int'(v_mem), 0);
    chk("arst_spk", int'(spike_valid), 0);
    chk("arst_st", int'(spike_time), 0);
    chk("arst_rdy", int'(in_ready), 0);
    chk("arst_wait", int'(o_wait), 0);
    $display("[TB] async reset mid-event -> v=%0d spk=%0d rdy=%0d", v_mem, spike_valid, in_ready);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    en = 0; in_valid = 0;
    tick();
    check_model("post_arst");

    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 99) < 6) ? 1'b0 : 1'b1;
      kill = ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0;
      cfg_we = ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0;
      cfg_vth   = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 600));
      cfg_refr  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      cfg_axon  = 8'($urandom_range(0, 255));
      cfg_vleak = 16'($urandom_range(0, 20));
      in_valid  = en && ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 5) in_weight = 16'($urandom_range(0, 65535));
      else in_weight = 16'(int'($urandom_range(0, 500)) - 200);
      if ($urandom_range(0, 99) < 5) in_interval = 16'($urandom_range(0, 65535));
      else in_interval = 16'($urandom_range(0, 40));
      tick();
      if (in_valid)
        $display("[TB] rnd %0d w=%0d int=%0d -> v=%0d spk=%0d wait=%0d",
                 i, $signed(in_weight), in_interval, v_mem, spike_valid, o_wait);
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
